// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths, FSM state encoding and port ids for the RAM arbiter
package ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin select
module rr_pick2
    import ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       any
);

    // A lone requester always wins; the pointer only breaks ties
    always_comb begin
        any    = |req;
        winner = PORT_A;
        if (req == 2'b11) begin
            winner = ptr;
        end else if (req[1]) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin sequencer for a single-port 1K x 8 RAM
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_e              state_q;
    logic                ptr_q;
    logic                win_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                cs_q;
    logic                rd_q;
    logic                wr_q;
    logic                a_gnt_q;
    logic                b_gnt_q;
    logic                a_rvalid_q;
    logic                b_rvalid_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;

    logic                pick_win;
    logic                pick_any;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_pick2 u_pick (
        .req    ({b_req, a_req}),
        .ptr    (ptr_q),
        .winner (pick_win),
        .any    (pick_any)
    );

    assign sel_we    = (pick_win == PORT_B) ? b_we    : a_we;
    assign sel_addr  = (pick_win == PORT_B) ? b_addr  : a_addr;
    assign sel_wdata = (pick_win == PORT_B) ? b_wdata : a_wdata;

    // Sequencer: strobes, grants and read returns are all registered with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PORT_A;
            win_q      <= PORT_A;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_q <= 1'b0;
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (pick_any) begin
                        // Latch the winner's request so later input changes cannot disturb it
                        win_q   <= pick_win;
                        ptr_q   <= ~pick_win;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cs_q    <= 1'b1;
                        wr_q    <= sel_we;
                        rd_q    <= ~sel_we;
                        a_gnt_q <= (pick_win == PORT_A);
                        b_gnt_q <= (pick_win == PORT_B);
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (we_q) begin
                        cs_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        // Keep cs/rd asserted so the RAM keeps driving its output
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (win_q == PORT_B) begin
                        b_rdata_q  <= ram_dout;
                        b_rvalid_q <= 1'b1;
                    end else begin
                        a_rdata_q  <= ram_dout;
                        a_rvalid_q <= 1'b1;
                    end
                    cs_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cs_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_cs   = cs_q;
    assign ram_rd   = rd_q;
    assign ram_wr   = wr_q;
    assign ram_addr = addr_q;
    assign ram_din  = wdata_q;
    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [9:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_cs, ram_rd, ram_wr;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    ram_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_cs   (ram_cs),
        .ram_rd   (ram_rd),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, read data valid the cycle after ram_rd; preload during reset
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[1]   <= 8'h11;
            mem[2]   <= 8'h22;
            ram_dout <= 8'h00;
        end else begin
            if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
            if (ram_cs && ram_rd) ram_dout <= mem[ram_addr];
        end
    end

    // rd and wr must never be asserted together
    always @(negedge clk) begin
        checks++;
        assert (!(ram_rd && ram_wr)) else begin
            errors++;
            $error("FAIL rd_wr_excl observed=rd%0b/wr%0b expected=not both", ram_rd, ram_wr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from a single port, checking grant, strobes and read return
    task automatic access(input logic port, input logic we, input logic [9:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        tick();
        chk("acc_gnt", 32'(port ? b_gnt : a_gnt), 32'd1);
        chk("acc_other_gnt", 32'(port ? a_gnt : b_gnt), 32'd0);
        chk("acc_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, {29'd0, 1'b1, ~we, we});
        chk("acc_addr", 32'(ram_addr), 32'(addr));
        if (we) chk("acc_din", 32'(ram_din), 32'(wdata));
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        if (we) begin
            chk("wr_done_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
        end else begin
            chk("capture_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'b110);
            chk("capture_no_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
            tick();
            chk("rd_rvalid", {30'd0, a_rvalid, b_rvalid}, port ? 32'b01 : 32'b10);
            chk("rd_rdata", 32'(port ? b_rdata : a_rdata), 32'(exp_rdata));
            chk("rd_done_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        tick();
        tick();
        chk("reset_outputs", {25'd0, a_gnt, a_rvalid, b_gnt, b_rvalid, ram_cs, ram_rd, ram_wr}, 32'd0);
        chk("reset_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
        chk("reset_addr_din", {14'd0, ram_addr, ram_din}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Grant A alone (pointer moves to B), then reset in the middle of the access
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 8'h77;
        tick();
        chk("pre_reset_gnt", 32'(a_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midacc_reset", {27'd0, a_gnt, b_gnt, ram_cs, ram_rd, ram_wr}, 32'd0);
        chk("midacc_reset_rv", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        #2;
        rst_n = 1'b1;
        a_req = 1'b0;

        // Contention: both read continuously; grants alternate starting with A
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h001;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h002;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("cont_gnt", {30'd0, a_gnt, b_gnt}, (g % 2 == 0) ? 32'b10 : 32'b01);
            chk("cont_addr", 32'(ram_addr), (g % 2 == 0) ? 32'h001 : 32'h002);
            tick();
            chk("cont_capture_no_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
            tick();
            chk("cont_rvalid", {30'd0, a_rvalid, b_rvalid}, (g % 2 == 0) ? 32'b10 : 32'b01);
            chk("cont_rdata", (g % 2 == 0) ? 32'(a_rdata) : 32'(b_rdata),
                (g % 2 == 0) ? 32'h11 : 32'h22);
            chk("cont_no_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        chk("cont_drained", {29'd0, ram_cs, a_gnt, b_gnt}, 32'd0);

        // Mixed: A writes 0x010 while B reads 0x010; pointer favours A
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_wdata = 8'h5A;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h010;
        tick();
        chk("mix_gnt", {30'd0, a_gnt, b_gnt}, 32'b10);
        chk("mix_wr", {29'd0, ram_cs, ram_rd, ram_wr}, 32'b101);
        chk("mix_din", 32'(ram_din), 32'h5A);
        a_req = 1'b0;
        a_addr = 10'h3AA; a_wdata = 8'hEE;
        tick();
        chk("mix_idle", {29'd0, ram_cs, a_gnt, b_gnt}, 32'd0);
        tick();
        chk("mix_b_gnt", {30'd0, a_gnt, b_gnt}, 32'b01);
        chk("mix_b_addr", 32'(ram_addr), 32'h010);
        b_req = 1'b0;
        tick();
        tick();
        chk("mix_b_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'b01);
        chk("mix_b_rdata", 32'(b_rdata), 32'h5A);
        chk("mix_a_rdata_kept", 32'(a_rdata), 32'h11);
        tick();
        chk("mix_rvalid_pulse", {30'd0, a_rvalid, b_rvalid}, 32'd0);

        // Single port A write then read at the top address
        access(1'b0, 1'b1, 10'h3FF, 8'hA5, 8'h00);
        access(1'b0, 1'b0, 10'h3FF, 8'h00, 8'hA5);

        // Boundary addresses from both ports
        access(1'b0, 1'b1, 10'h000, 8'hC3, 8'h00);
        access(1'b1, 1'b1, 10'h3FF, 8'h3C, 8'h00);
        access(1'b1, 1'b0, 10'h000, 8'h00, 8'hC3);
        access(1'b0, 1'b0, 10'h3FF, 8'h00, 8'h3C);
        chk("bnd_b_rdata_kept", 32'(b_rdata), 32'hC3);

        // Idle hold: nothing moves and rdata stays put
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_strobes", {27'd0, ram_cs, ram_rd, ram_wr, a_gnt, b_gnt}, 32'd0);
            chk("idle_a_rdata", 32'(a_rdata), 32'h3C);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
